// File: rtl/sc_pkg.sv
// Shared types and the per-pair gate function for the stochastic-computing engine.
package sc_pkg;

    typedef enum logic [1:0] {
        SC_AND  = 2'b00,
        SC_OR   = 2'b01,
        SC_NAND = 2'b10,
        SC_XNOR = 2'b11
    } sc_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } sc_state_e;

    function automatic logic sc_gate(input sc_mode_e i_mode, input logic i_a, input logic i_b);
        logic r;
        case (i_mode)
            SC_AND:  r = i_a & i_b;
            SC_OR:   r = i_a | i_b;
            SC_NAND: r = ~(i_a & i_b);
            SC_XNOR: r = ~(i_a ^ i_b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sc_sobol_ch.sv
// One Sobol bitstream channel: Gray-code x update from the shared step index k,
// and the unsigned comparator that turns the operand into a stream bit.
module sc_sobol_ch
    import sc_pkg::*;
#(
    parameter int WIDTH   = 6,
    parameter int LOG_LEN = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_step,
    input  logic [LOG_LEN-1:0]         i_k,
    input  logic [WIDTH-1:0]           i_num,
    input  logic [LOG_LEN*WIDTH-1:0]   i_dir,
    output logic                       o_s
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] w_dir_sel;
    logic             w_found;

    // Lowest zero bit of k picks the direction number; all-ones k selects nothing.
    always_comb begin
        w_dir_sel = '0;
        w_found   = 1'b0;
        for (int j = 0; j < LOG_LEN; j++) begin
            if (!w_found && !i_k[j]) begin
                w_dir_sel = i_dir[j*WIDTH +: WIDTH];
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
        end else if (i_clear) begin
            r_x <= '0;
        end else if (i_step && w_found) begin
            r_x <= r_x ^ w_dir_sel;
        end
    end

    assign o_s = (i_num > r_x);

endmodule

// File: rtl/sc_engine.sv
// Stochastic-computing engine: per-pair Sobol streams through a selectable gate,
// accumulated serially over 2**LOG_LEN cycles with a start/done handshake.
module sc_engine
    import sc_pkg::*;
#(
    parameter int NUM_PAIRS = 4,
    parameter int WIDTH     = 6,
    parameter int LOG_LEN   = 5,
    parameter int RES_W     = $clog2(NUM_PAIRS*(2**LOG_LEN)+1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en_in,
    input  logic                                   clr,
    input  logic [1:0]                             mode,
    input  logic [2*NUM_PAIRS*WIDTH-1:0]           num,
    input  logic [2*NUM_PAIRS*LOG_LEN*WIDTH-1:0]   dir,
    output logic                                   busy,
    output logic                                   en_out,
    output logic [RES_W-1:0]                       result
);

    localparam int NCH = 2*NUM_PAIRS;

    sc_state_e                               r_state;
    sc_state_e                               w_state_nxt;
    logic [LOG_LEN-1:0]                      r_k;
    logic [RES_W-1:0]                        r_acc;
    logic [RES_W-1:0]                        r_result;
    logic                                    r_en_out;
    sc_mode_e                                r_mode;
    logic [2*NUM_PAIRS*WIDTH-1:0]            r_num;
    logic [2*NUM_PAIRS*LOG_LEN*WIDTH-1:0]    r_dir;

    logic                                    w_start;
    logic                                    w_finish;
    logic                                    w_last;
    logic                                    w_step;
    logic [NCH-1:0]                          w_s;
    logic [NUM_PAIRS-1:0]                    w_g;
    logic [RES_W-1:0]                        w_pop;

    assign w_last = &r_k;
    assign w_step = (r_state == RUN) && !w_last;

    // clr wins over both a start request and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en_in) begin
                        w_state_nxt = RUN;
                        w_start     = 1'b1;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_finish    = 1'b1;
                    end
                end
                DONE: begin
                    if (en_in) begin
                        w_state_nxt = RUN;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_en_out <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_en_out <= w_finish;
            if (clr || w_start) begin
                r_k   <= '0;
                r_acc <= '0;
            end else if (r_state == RUN) begin
                r_k   <= r_k + LOG_LEN'(1);
                r_acc <= r_acc + w_pop;
                if (w_last) begin
                    r_result <= r_acc + w_pop;
                end
            end
        end
    end

    // Operand snapshot: inputs may change freely while a run is in progress.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_num  <= num;
            r_dir  <= dir;
            r_mode <= sc_mode_e'(mode);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sc_sobol_ch #(
            .WIDTH   (WIDTH),
            .LOG_LEN (LOG_LEN)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_start),
            .i_step  (w_step),
            .i_k     (r_k),
            .i_num   (r_num[c*WIDTH +: WIDTH]),
            .i_dir   (r_dir[c*LOG_LEN*WIDTH +: LOG_LEN*WIDTH]),
            .o_s     (w_s[c])
        );
    end

    always_comb begin
        w_g   = '0;
        w_pop = '0;
        for (int p = 0; p < NUM_PAIRS; p++) begin
            w_g[p] = sc_gate(r_mode, w_s[2*p], w_s[2*p+1]);
            w_pop  = w_pop + RES_W'(w_g[p]);
        end
    end

    assign busy   = (r_state == RUN);
    assign en_out = r_en_out;
    assign result = r_result;

endmodule
